// File: rtl/any1_pkg.sv
// rtl/any1_pkg.sv - ANY-1 shared reorder-buffer defaults and entry-state types
package any1_pkg;

    localparam int ROB_ENTRIES = 64;
    localparam int ROB_ALLOC_W = 2;
    localparam int ROB_CMT_W   = 2;
    localparam int ROB_RW      = $clog2(ROB_ENTRIES);

    typedef logic [ROB_RW-1:0] Rid;

    typedef struct packed {
        logic v;
        logic done;
        logic exc;
    } sRobState;

endpackage

// File: rtl/any1_rob_cmt_sel.sv
// rtl/any1_rob_cmt_sel.sv - in-order commit selector over the ROB head window
module any1_rob_cmt_sel
    import any1_pkg::*;
#(
    parameter int CMT_W = ROB_CMT_W,
    parameter int AW    = $clog2(CMT_W + 1)
) (
    input  sRobState         win [CMT_W],
    output logic [CMT_W-1:0] cmt_v,
    output logic             exc,
    output logic [AW-1:0]    adv
);

    logic go;

    always_comb begin
        cmt_v = '0;
        adv   = '0;
        go    = 1'b1;
        for (int k = 0; k < CMT_W; k++) begin
            // a faulting entry retires only from slot 0, and nothing retires behind it
            go       = go & win[k].v & win[k].done & ((k == 0) | ~win[k].exc);
            cmt_v[k] = go;
            if (go) begin
                adv = adv + AW'(1);
            end
            if (win[k].exc) begin
                go = 1'b0;
            end
        end
        exc = cmt_v[0] & win[0].exc;
    end

endmodule

// File: rtl/any1_rob_ctrl.sv
// rtl/any1_rob_ctrl.sv - parametrised ROB control: allocate, complete, commit, squash, flush
module any1_rob_ctrl
    import any1_pkg::*;
#(
    parameter int ENTRIES = ROB_ENTRIES,
    parameter int RW      = $clog2(ENTRIES),
    parameter int ALLOC_W = ROB_ALLOC_W,
    parameter int CMT_W   = ROB_CMT_W
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [$clog2(ALLOC_W+1)-1:0] alloc_cnt_i,
    output logic                         alloc_rdy_o,
    output logic [ALLOC_W*RW-1:0]        alloc_rid_o,
    input  logic                         done_i,
    input  logic [RW-1:0]                done_rid_i,
    input  logic                         done_exc_i,
    input  logic                         flush_i,
    input  logic [RW-1:0]                flush_rid_i,
    output logic [CMT_W-1:0]             cmt_v_o,
    output logic [CMT_W*RW-1:0]          cmt_rid_o,
    output logic                         exc_o,
    output logic [RW-1:0]                exc_rid_o,
    output logic [RW:0]                  count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int AW = $clog2(ALLOC_W + 1);
    localparam int CW = $clog2(CMT_W + 1);

    logic [RW-1:0]      head;
    logic [RW-1:0]      tail;
    logic [RW:0]        count;
    sRobState           st [ENTRIES];

    sRobState           win [CMT_W];
    logic [RW-1:0]      win_rid [CMT_W];
    logic [RW-1:0]      alloc_rid [ALLOC_W];
    logic [CMT_W-1:0]   sel_v;
    logic               sel_exc;
    logic [CW-1:0]      adv;
    logic [RW-1:0]      flush_age;
    logic [RW:0]        free;
    logic [RW:0]        count_nxt;
    logic [ENTRIES-1:0] squash;

    assign flush_age = flush_rid_i - head;
    assign free      = (RW+1)'(ENTRIES) - count;

    // entries younger than the branch must not retire in the cycle they are squashed
    always_comb begin
        for (int k = 0; k < CMT_W; k++) begin
            win_rid[k] = head + RW'(k);
            win[k]     = st[win_rid[k]];
            if (flush_i && (RW'(k) > flush_age)) begin
                win[k].v = 1'b0;
            end
        end
    end

    any1_rob_cmt_sel #(.CMT_W(CMT_W), .AW(CW)) u_cmt_sel (
        .win   (win),
        .cmt_v (sel_v),
        .exc   (sel_exc),
        .adv   (adv)
    );

    always_comb begin
        alloc_rid_o = '0;
        cmt_rid_o   = '0;
        for (int k = 0; k < ALLOC_W; k++) begin
            alloc_rid[k]                = tail + RW'(k);
            alloc_rid_o[k*RW +: RW]     = alloc_rid[k];
        end
        for (int k = 0; k < CMT_W; k++) begin
            cmt_rid_o[k*RW +: RW] = win_rid[k];
        end
        for (int i = 0; i < ENTRIES; i++) begin
            squash[i] = flush_i & (RW'(RW'(i) - head) > flush_age);
        end
    end

    assign cmt_v_o     = rst_ni ? sel_v : '0;
    assign exc_o       = rst_ni & sel_exc;
    assign exc_rid_o   = head;
    assign count_o     = count;
    assign empty_o     = (count == '0);
    assign full_o      = (count == (RW+1)'(ENTRIES));
    // freed slots from a same-cycle commit are not reusable until the next cycle
    assign alloc_rdy_o = rst_ni & ~flush_i & ~exc_o & (alloc_cnt_i != '0)
                       & (alloc_cnt_i <= AW'(ALLOC_W))
                       & ((RW+1)'(alloc_cnt_i) <= free);

    always_comb begin
        if (flush_i) begin
            count_nxt = (RW+1)'(flush_age) + (RW+1)'(1) - (RW+1)'(adv);
        end else if (alloc_rdy_o) begin
            count_nxt = count + (RW+1)'(alloc_cnt_i) - (RW+1)'(adv);
        end else begin
            count_nxt = count - (RW+1)'(adv);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                st[i] <= '0;
            end
        end else if (exc_o) begin
            for (int i = 0; i < ENTRIES; i++) begin
                st[i] <= '0;
            end
            head  <= head + RW'(1);
            tail  <= head + RW'(1);
            count <= '0;
        end else begin
            if (done_i && st[done_rid_i].v) begin
                st[done_rid_i].done <= 1'b1;
                st[done_rid_i].exc  <= done_exc_i;
            end
            for (int k = 0; k < CMT_W; k++) begin
                if (cmt_v_o[k]) begin
                    st[win_rid[k]].v <= 1'b0;
                end
            end
            if (flush_i) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    if (squash[i]) begin
                        st[i].v <= 1'b0;
                    end
                end
                tail <= flush_rid_i + RW'(1);
            end else if (alloc_rdy_o) begin
                for (int k = 0; k < ALLOC_W; k++) begin
                    if (AW'(k) < alloc_cnt_i) begin
                        st[alloc_rid[k]] <= '{v: 1'b1, done: 1'b0, exc: 1'b0};
                    end
                end
                tail <= tail + RW'(alloc_cnt_i);
            end
            head  <= head + RW'(adv);
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && flush_i && !exc_o) begin
            assert (st[flush_rid_i].v);
        end
    end

endmodule

// File: tb/tb_any1_rob_ctrl.sv
// tb/tb_any1_rob_ctrl.sv - directed plus randomized self-checking bench for any1_rob_ctrl
module tb_any1_rob_ctrl;

    localparam int N  = 8;
    localparam int RW = 3;
    localparam int AL = 2;
    localparam int CM = 2;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic [1:0]       alloc_cnt_i = '0;
    logic             alloc_rdy_o;
    logic [AL*RW-1:0] alloc_rid_o;
    logic             done_i = 1'b0;
    logic [RW-1:0]    done_rid_i = '0;
    logic             done_exc_i = 1'b0;
    logic             flush_i = 1'b0;
    logic [RW-1:0]    flush_rid_i = '0;
    logic [CM-1:0]    cmt_v_o;
    logic [CM*RW-1:0] cmt_rid_o;
    logic             exc_o;
    logic [RW-1:0]    exc_rid_o;
    logic [RW:0]      count_o;
    logic             empty_o;
    logic             full_o;

    always #5 clk = ~clk;

    any1_rob_ctrl #(.ENTRIES(N), .ALLOC_W(AL), .CMT_W(CM)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .alloc_cnt_i (alloc_cnt_i),
        .alloc_rdy_o (alloc_rdy_o),
        .alloc_rid_o (alloc_rid_o),
        .done_i      (done_i),
        .done_rid_i  (done_rid_i),
        .done_exc_i  (done_exc_i),
        .flush_i     (flush_i),
        .flush_rid_i (flush_rid_i),
        .cmt_v_o     (cmt_v_o),
        .cmt_rid_o   (cmt_rid_o),
        .exc_o       (exc_o),
        .exc_rid_o   (exc_rid_o),
        .count_o     (count_o),
        .empty_o     (empty_o),
        .full_o      (full_o)
    );

    int checks = 0;
    int errors = 0;

    // reference ROB: in-flight rids oldest first, plus per-rid completion flags
    int q[$];
    int mhead = 0;
    bit mdone [N];
    bit mexc  [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pos(input int r);
        foreach (q[i]) if (q[i] == r) return i;
        return -1;
    endfunction

    task automatic step(input int a, input bit d, input int dr, input bit de,
                        input bit f, input int fr, input bit r);
        int t, fage, n;
        bit ex, rdy;
        @(negedge clk);
        rst_ni      = r;
        alloc_cnt_i = 2'(a);
        done_i      = d;
        done_rid_i  = 3'(dr);
        done_exc_i  = de;
        flush_i     = f;
        flush_rid_i = 3'(fr);
        #1;
        t    = (mhead + q.size()) % N;
        fage = f ? pos(fr) : N;
        if (f && fage < 0) chk("flush_rid_in_flight", 0, 1);
        n = 0;
        for (int k = 0; k < CM && k < q.size(); k++) begin
            if (f && k > fage) break;
            if (!mdone[q[k]]) break;
            if (k > 0 && mexc[q[k]]) break;
            n++;
            if (mexc[q[k]]) break;
        end
        if (!r) n = 0;
        ex = 1'b0;
        if (n > 0) ex = mexc[q[0]];
        rdy = r && a != 0 && a <= N - q.size() && !f && !ex;

        chk("count", count_o, q.size());
        chk("empty", empty_o, q.size() == 0);
        chk("full", full_o, q.size() == N);
        chk("alloc_rdy", alloc_rdy_o, rdy);
        for (int k = 0; k < AL; k++) chk("alloc_rid", alloc_rid_o[k*RW +: RW], (t + k) % N);
        chk("cmt_v", cmt_v_o, (1 << n) - 1);
        for (int k = 0; k < n; k++) chk("cmt_rid", cmt_rid_o[k*RW +: RW], q[k]);
        chk("exc", exc_o, ex);
        if (ex) chk("exc_rid", exc_rid_o, q[0]);

        if (!r) begin
            q.delete();
            mhead = 0;
            for (int i = 0; i < N; i++) begin
                mdone[i] = 0;
                mexc[i]  = 0;
            end
        end else begin
            if (d && pos(dr) >= 0) begin
                mdone[dr] = 1;
                mexc[dr]  = de;
            end
            if (ex) begin
                mhead = (q[0] + 1) % N;
                q.delete();
            end else begin
                if (f) while (q.size() > fage + 1) void'(q.pop_back());
                for (int k = 0; k < n; k++) void'(q.pop_front());
                mhead = (mhead + n) % N;
                if (rdy) begin
                    for (int k = 0; k < a; k++) begin
                        q.push_back((t + k) % N);
                        mdone[(t + k) % N] = 0;
                        mexc[(t + k) % N]  = 0;
                    end
                end
            end
        end
    endtask

    task automatic idle();              step(0, 0, 0, 0, 0, 0, 1); endtask
    task automatic do_reset();          step(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic alloc(input int a);  step(a, 0, 0, 0, 0, 0, 1); endtask
    task automatic done(input int r, input bit e); step(0, 1, r, e, 0, 0, 1); endtask

    initial begin
        int a, dr, fr;
        bit d, de, f, r;

        do_reset();
        do_reset();
        idle();
        chk("reset_empty", empty_o, 1);
        chk("reset_count", count_o, 0);
        chk("reset_full", full_o, 0);

        // basic allocate and out-of-order completion
        alloc(2);
        chk("alloc_first_rdy", alloc_rdy_o, 1);
        chk("alloc_first_rids", alloc_rid_o, 6'd8);
        done(1, 0);
        chk("count_two", count_o, 2);
        done(0, 0);
        chk("no_commit_before_rid0", cmt_v_o, 0);
        idle();
        chk("commit_pair", cmt_v_o, 2'b11);
        chk("commit_pair_rids", cmt_rid_o, 6'd8);
        idle();
        chk("drained_empty", empty_o, 1);
        chk("model_head_two", mhead, 2);

        // fill, refuse, same-cycle commit does not free slots
        do_reset();
        repeat (4) alloc(2);
        idle();
        chk("fill_full", full_o, 1);
        chk("fill_count", count_o, 8);
        step(1, 1, 1, 0, 0, 0, 1);
        chk("full_refuse", alloc_rdy_o, 0);
        done(0, 0);
        alloc(2);
        chk("full_commit_pair", cmt_v_o, 2'b11);
        chk("no_bypass_refuse", alloc_rdy_o, 0);
        alloc(2);
        chk("wrap_accept", alloc_rdy_o, 1);
        chk("wrap_rids", alloc_rid_o, 6'd8);

        // exception commits only from slot 0, then full flush
        do_reset();
        alloc(2);
        alloc(2);
        done(0, 0);
        done(1, 1);
        chk("exc_cycle_a_cmt", cmt_v_o, 2'b01);
        chk("exc_cycle_a_exc", exc_o, 0);
        done(2, 0);
        chk("exc_cycle_b_exc", exc_o, 1);
        chk("exc_cycle_b_rid", exc_rid_o, 1);
        step(1, 1, 3, 0, 0, 0, 1);
        chk("exc_after_empty", empty_o, 1);
        chk("exc_after_tail", alloc_rid_o[2:0], 2);
        chk("model_exc_head", mhead, 2);

        // mispredict squash with a same-cycle allocate request
        do_reset();
        repeat (3) alloc(2);
        step(2, 0, 0, 0, 1, 2, 1);
        chk("flush_blocks_alloc", alloc_rdy_o, 0);
        done(4, 0);
        chk("flush_count", count_o, 3);
        chk("flush_tail", alloc_rid_o[2:0], 3);
        idle();
        chk("late_done_ignored", count_o, 3);

        // squash ages computed across the wrap point
        do_reset();
        repeat (3) alloc(2);
        for (int i = 0; i < 6; i++) done(i, 0);
        repeat (3) idle();
        chk("model_head_six", mhead, 6);
        alloc(2);
        chk("wrap_alloc_rids", alloc_rid_o, 6'd62);
        alloc(2);
        step(0, 0, 0, 0, 1, 7, 1);
        idle();
        chk("wrap_flush_count", count_o, 2);
        chk("wrap_flush_tail", alloc_rid_o[2:0], 0);

        // reset overrides a pending commit, done and allocate
        do_reset();
        alloc(2);
        alloc(2);
        alloc(1);
        done(0, 0);
        step(2, 1, 1, 0, 0, 0, 0);
        chk("rst_no_commit", cmt_v_o, 0);
        chk("rst_no_alloc", alloc_rdy_o, 0);
        chk("rst_count_pre", count_o, 5);
        idle();
        chk("rst_count_post", count_o, 0);
        chk("rst_empty_post", empty_o, 1);

        for (int i = 0; i < 4000; i++) begin
            a  = $urandom_range(0, 2);
            d  = ($urandom_range(0, 3) != 0);
            dr = (q.size() > 0 && $urandom_range(0, 4) != 0)
                 ? q[$urandom_range(0, q.size() - 1)] : $urandom_range(0, N - 1);
            de = ($urandom_range(0, 9) == 0);
            f  = (q.size() > 0 && $urandom_range(0, 11) == 0);
            fr = f ? q[$urandom_range(0, q.size() - 1)] : $urandom_range(0, N - 1);
            r  = ($urandom_range(0, 199) != 0);
            step(a, d, dr, de, f, fr, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/any1_rob_ctrl.md
# any1_rob_ctrl

Parametrised reorder-buffer control for the ANY-1 out-of-order core. Generalises the fixed 64-entry ROB to configurable depth, allocate width and commit width. Tracks entry state (valid, done, exception) only; payload storage stays in the separate sReorderEntry array. Sits between decode/rename (allocation), the functional units (completion) and the architectural commit stage, and handles branch-mispredict squash and exception flush.

## Interface
- ENTRIES, 64, ROB depth; power of two, 4..256
- RW, $clog2(ENTRIES), rid width
- ALLOC_W, 2, max entries allocated per cycle, 1..4
- CMT_W, 2, max entries committed per cycle, 1..4
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- alloc_cnt_i  in  $clog2(ALLOC_W+1)  entries requested this cycle (0 = none)
- alloc_rdy_o  out  1  request accepted this cycle
- alloc_rid_o  out  ALLOC_W*RW  rids assigned, slot 0 oldest; valid when alloc_rdy_o
- done_i  in  1  unit writeback strobe
- done_rid_i  in  RW  completing entry
- done_exc_i  in  1  completing entry raised an exception
- flush_i  in  1  mispredict squash
- flush_rid_i  in  RW  branch entry; it survives, all younger squash
- cmt_v_o  out  CMT_W  per-slot commit strobe, contiguous from bit 0
- cmt_rid_o  out  CMT_W*RW  committing rids
- exc_o  out  1  slot-0 commit is an exception; full flush follows
- exc_rid_o  out  RW  faulting rid
- count_o  out  RW+1  occupied entries
- empty_o / full_o  out  1  count==0 / count==ENTRIES

## Operation
- State: head, tail (RW bits, wrap modulo ENTRIES), count (RW+1), per-entry v, done, exc.
- Allocate: alloc_rdy_o = (alloc_cnt_i <= ENTRIES-count) & ~flush_i & ~exc_o & alloc_cnt_i!=0. alloc_rid_o slot k = tail+k (mod ENTRIES), driven combinationally regardless. On accept: set v, clear done/exc for those entries; tail += alloc_cnt_i.
- Done: if v[done_rid_i], set done and exc<=done_exc_i. Done to an invalid (squashed) entry is ignored. Visible to commit next cycle.
- Commit: scan head..head+CMT_W-1; slot k commits if entries 0..k all v&done and none of 0..k-1 has exc. An exc entry commits only in slot 0: if head has exc, cmt_v_o=1, exc_o=1, exc_rid_o=head. Committed entries clear v; head advances by number committed.
- Exception flush (cycle exc_o is high): all entries cleared, head=tail=head+1, count=0.
- Mispredict flush: age(r)=(r-head) mod ENTRIES. Entries with age > age(flush_rid_i) clear v; tail=flush_rid_i+1; count=age(flush_rid_i)+1 minus same-cycle commits. flush_rid_i must name a valid entry; otherwise behaviour undefined (assertion).
- Priority: reset > exception flush > mispredict flush > allocate. Commit of older entries proceeds in the same cycle as mispredict flush. Done in same cycle as a flush squashing that rid is discarded.

## Timing
- Reset (rst_ni low at clk edge): head=tail=0, count=0, all v/done/exc=0; outputs: alloc_rdy_o=0 during reset, cmt_v_o=0, exc_o=0, empty_o=1, full_o=0, count_o=0.
- alloc_rdy_o, alloc_rid_o, cmt_*, exc_* combinational from registered state and current inputs; state updates on next edge.
- Done-to-commit latency 1 cycle. Allocate-to-earliest-commit 2 cycles.
- Full: alloc with count==ENTRIES refused; alloc and commit same cycle uses pre-commit count (no bypass of freed slots).
- Wrap: tail ENTRIES-1 + 2 → 1; ages computed modulo.

## Structure
- Package any1_pkg additions: ROB_ALLOC_W, ROB_CMT_W defaults; typedef sRobState {v, done, exc}; Rid rid width derived from ROB_ENTRIES.
- Sub-module any1_rob_cmt_sel: combinational CMT_W-wide commit selector (inputs head-window state, outputs cmt_v, exc, advance count).

## Test plan
- ENTRIES=8, ALLOC_W=2, CMT_W=2: reset, alloc 2 → rids 0,1, count 2; done rid1 then rid0 → cmt_v_o=2'b11 one cycle after rid0 done, head=2.
- Fill: alloc 2 ×4 → full_o=1, count 8; alloc 1 refused; commit 2 then alloc 2 accepted next cycle with rids 0,1 (wrap).
- Exception: alloc rids 0..3, done 0 exc=0, done 1 exc=1, done 2,3 → cycle A cmt rid0 only; cycle B exc_o=1 rid1; then empty_o=1, head=tail=2.
- Mispredict: rids 0..5 valid, flush_i rid 2 with alloc 2 same cycle → alloc_rdy_o=0, tail=3, count=3; late done rid4 ignored.
- Wrap age: head=6, entries 6,7,0,1, flush rid 7 → entries 0,1 squashed, tail=0, count=2.
- Reset mid-operation: rst_ni low with count=5, done_i and alloc asserted → next cycle count 0, empty_o=1, no commit.
